// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter.
// Sends one command byte (e.g. 0xED, 0xF4, 0xFF) to the keyboard over the shared
// open-drain ps2_clk/ps2_data lines. Each *_oe output drives an external tri-state
// (1 = pull the line low, 0 = release it). busy gates the companion receiver.
// Optional build macro: PS2_TX_TIMEOUT_EN adds a watchdog on the device clock.
// Without that macro, timeout is tied low and the FSM waits indefinitely.

module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);

    if (INHIBIT_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
        $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be non-zero");
    end

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        STOP,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t           state;
    logic             clk_s1;
    logic             sync_clk;
    logic             sync_clk_d;
    logic             data_s1;
    logic             sync_data;
    logic             fall;
    logic [8:0]       sr;
    logic [3:0]       bitcnt;
    logic             ack_ok;
    logic [INH_W-1:0] inh_cnt;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
`endif

    assign fall = sync_clk_d & ~sync_clk;

    // Two-flop synchronisers for the raw pins plus a delayed copy of the clock for edge detect
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_s1     <= 1'b1;
            sync_clk   <= 1'b1;
            sync_clk_d <= 1'b1;
            data_s1    <= 1'b1;
            sync_data  <= 1'b1;
        end else begin
            clk_s1     <= ps2_clk_i;
            sync_clk   <= clk_s1;
            sync_clk_d <= sync_clk;
            data_s1    <= ps2_data_i;
            sync_data  <= data_s1;
        end
    end

    // Transmit FSM with registered line drivers and status pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout     <= 1'b0;
            sr          <= '0;
            bitcnt      <= '0;
            ack_ok      <= 1'b0;
            inh_cnt     <= '0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
        end else begin
            done    <= 1'b0;
            ack_err <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    // tx_ready rises one cycle after the return, so an accept never lands on a done cycle
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        sr         <= {~^tx_data, tx_data};
                        inh_cnt    <= '0;
                        ps2_clk_oe <= 1'b1;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;
                        bitcnt      <= '0;
                        state       <= RTS;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end
                RTS: begin
                    // First device fall presents data bit 0
                    if (fall) begin
                        ps2_data_oe <= ~sr[0];
                        sr          <= {1'b0, sr[8:1]};
                        bitcnt      <= bitcnt + 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        ps2_data_oe <= ~sr[0];
                        sr          <= {1'b0, sr[8:1]};
                        bitcnt      <= bitcnt + 1'b1;
                        if (bitcnt == 4'd8) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (fall) begin
                        ps2_data_oe <= 1'b0;
                        state       <= ACK;
                    end
                end
                ACK: begin
                    if (fall) begin
                        ack_ok <= ~sync_data;
                        state  <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (sync_clk && sync_data) begin
                        done    <= ack_ok;
                        ack_err <= ~ack_ok;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
`ifdef PS2_TX_TIMEOUT_EN
            // Watchdog overrides the case above; held clear through INHIBIT so RTS starts from zero
            if (state == IDLE || state == INHIBIT) begin
                wd_cnt <= '0;
            end else if (fall) begin
                wd_cnt <= '0;
            end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                wd_cnt      <= '0;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                timeout     <= 1'b1;
                done        <= 1'b0;
                ack_err     <= 1'b0;
                busy        <= 1'b0;
                state       <= IDLE;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
`endif
        end
    end

`ifndef PS2_TX_TIMEOUT_EN
    logic unused_timeout_reg;
    assign unused_timeout_reg = timeout;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed + randomized bench for ps2_host_tx with a keyboard BFM
// on wired-AND open-drain lines. Timing is scaled down (short inhibit, fast device clock).
// Build with PS2_TX_TIMEOUT_EN to exercise the watchdog path.

module tb_ps2_host_tx;

    localparam int unsigned INH  = 100;
    localparam int unsigned TMO  = 1000;
    localparam int unsigned HALF = 20;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout;
    logic       bfm_clk;
    logic       bfm_data;
    logic       ps2_clk_i;
    logic       ps2_data_i;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_err  = 0;
    int n_tmo  = 0;
    int n_bad  = 0;
    int exp_done = 0;
    int exp_err  = 0;
    bit mon_en = 1'b0;
    logic doe_prev = 1'b0;
    logic clk_line_prev = 1'b1;

    // Open-drain wired-AND of host and device drivers
    assign ps2_clk_i  = bfm_clk & ~ps2_clk_oe;
    assign ps2_data_i = bfm_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected line sequence seen by the device: start, 8 data LSB first, odd parity, stop
    function automatic logic [10:0] expect_frame(input logic [7:0] d);
        int ones;
        logic [10:0] f;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i + 1] = d[i];
            ones += int'(d[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Pulse counters and the rule that host data only moves while the clock line is low
    always @(negedge clk) begin
        if (done === 1'b1) n_done++;
        if (ack_err === 1'b1) n_err++;
        if (timeout === 1'b1) n_tmo++;
        if ((done === 1'b1 || ack_err === 1'b1) && busy !== 1'b0) n_bad++;
        if (mon_en && ps2_data_oe !== doe_prev)
            chk("data_oe_moves_with_clk_high", {31'b0, clk_line_prev}, 32'd0);
        doe_prev      = ps2_data_oe;
        clk_line_prev = ps2_clk_i;
    end

    task automatic send(input logic [7:0] d);
        int t;
        t = 0;
        while (tx_ready !== 1'b1 && t < 1000) begin
            cyc(1);
            t++;
        end
        chk("tx_ready_before_send", {31'b0, tx_ready}, 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
    endtask

    // Keyboard BFM: measures inhibit, clocks 11 falls, samples bits before each rise
    task automatic dev_frame(input int abort_at, input int stop_at, input bit do_ack,
                             output logic [10:0] bits, output int inh_len);
        int t;
        bits    = '0;
        inh_len = 0;
        t       = 0;
        while (ps2_clk_oe !== 1'b1 && t < 1000) begin
            cyc(1);
            t++;
        end
        while (ps2_clk_oe === 1'b1 && inh_len < int'(5 * INH)) begin
            inh_len++;
            cyc(1);
        end
        bits[0] = ps2_data_i;
        cyc(10);
        for (int k = 1; k <= 11; k++) begin
            bfm_clk = 1'b0;
            if (k == stop_at) return;
            if (k == abort_at) begin
                cyc(4);
                rst = 1'b0;
                cyc(1);
                chk("rst_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
                chk("rst_data_oe", {31'b0, ps2_data_oe}, 32'd0);
                chk("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
                chk("rst_busy", {31'b0, busy}, 32'd0);
                rst     = 1'b1;
                bfm_clk = 1'b1;
                return;
            end
            cyc(HALF);
            if (k <= 10) bits[k] = ps2_data_i;
            bfm_clk = 1'b1;
            if (k == 10 && do_ack) bfm_data = 1'b0;
            if (k == 11) begin
                bfm_data = 1'b1;
                return;
            end
            cyc(HALF);
        end
    endtask

    task automatic wait_idle(input bit exp_ack);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 500) begin
            cyc(1);
            t++;
        end
        chk("return_to_idle", {31'b0, busy}, 32'd0);
        chk("done_on_return", {31'b0, done}, {31'b0, exp_ack});
        chk("ack_err_on_return", {31'b0, ack_err}, {31'b0, !exp_ack});
        chk("ready_low_on_return", {31'b0, tx_ready}, 32'd0);
        cyc(1);
        chk("ready_after_return", {31'b0, tx_ready}, 32'd1);
        chk("pulse_one_cycle", {31'b0, done | ack_err}, 32'd0);
    endtask

    task automatic txn(input logic [7:0] d, input bit do_ack, input bit pre_toggle);
        logic [10:0] bits;
        int inh, d0, e0;
        d0 = n_done;
        e0 = n_err;
        send(d);
        if (pre_toggle) begin
            repeat (3) begin
                bfm_clk = 1'b0;
                cyc(5);
                bfm_clk = 1'b1;
                cyc(5);
            end
            chk("inhibit_ignores_device_clk", {31'b0, ps2_clk_oe}, 32'd1);
        end
        dev_frame(0, 0, do_ack, bits, inh);
        chk("inhibit_length", inh, pre_toggle ? INH - 30 : INH);
        chk("frame_bits", {21'b0, bits}, {21'b0, expect_frame(d)});
        wait_idle(do_ack);
        cyc(1);
        chk("done_count", n_done - d0, {31'b0, do_ack});
        chk("ack_err_count", n_err - e0, {31'b0, !do_ack});
        exp_done += int'(do_ack);
        exp_err  += int'(!do_ack);
    endtask

    initial begin
        logic [10:0] bits;
        int inh, n, d0, e0;
        logic [7:0] rd;
        bit ra;

        rst      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        bfm_clk  = 1'b1;
        bfm_data = 1'b1;
        cyc(3);
        chk("reset_tx_ready", {31'b0, tx_ready}, 32'd1);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
        chk("reset_data_oe", {31'b0, ps2_data_oe}, 32'd0);
        chk("reset_pulses", {29'b0, done, ack_err, timeout}, 32'd0);
        rst = 1'b1;
        cyc(2);
        mon_en = 1'b1;

        // Device clock activity while idle is ignored
        repeat (3) begin
            bfm_clk = 1'b0;
            cyc(5);
            bfm_clk = 1'b1;
            cyc(5);
        end
        chk("idle_ignores_clk_ready", {31'b0, tx_ready}, 32'd1);
        chk("idle_ignores_clk_busy", {31'b0, busy}, 32'd0);

        txn(8'hF4, 1'b1, 1'b0);
        txn(8'hED, 1'b0, 1'b0);

        // Byte held on tx_valid during a frame is taken only after the return to idle
        d0 = n_done;
        send(8'h00);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        dev_frame(0, 0, 1'b1, bits, inh);
        chk("held_first_frame", {21'b0, bits}, {21'b0, expect_frame(8'h00)});
        wait_idle(1'b1);
        cyc(1);
        chk("held_accept_busy", {31'b0, busy}, 32'd1);
        tx_valid = 1'b0;
        dev_frame(0, 0, 1'b1, bits, inh);
        chk("held_inhibit_length", inh, INH);
        chk("held_second_frame", {21'b0, bits}, {21'b0, expect_frame(8'h55)});
        wait_idle(1'b1);
        chk("held_done_count", n_done - d0, 32'd2);
        exp_done += 2;

        // Reset in the middle of a frame
        d0 = n_done;
        e0 = n_err;
        send(8'hA5);
        dev_frame(5, 0, 1'b1, bits, inh);
        cyc(50);
        chk("abort_no_done", n_done - d0, 32'd0);
        chk("abort_no_ack_err", n_err - e0, 32'd0);
        chk("abort_idle", {31'b0, busy}, 32'd0);

        // Device stops clocking after fall 3
        mon_en = 1'b0;
        send(8'h3C);
        dev_frame(0, 3, 1'b1, bits, inh);
        n = 0;
        while (timeout !== 1'b1 && n < int'(3 * TMO)) begin
            cyc(1);
            n++;
        end
`ifdef PS2_TX_TIMEOUT_EN
        // Two synchroniser stages plus the fall-detect cycle precede the watchdog start
        chk("timeout_latency", n, TMO + 3);
        chk("timeout_clk_released", {31'b0, ps2_clk_oe}, 32'd0);
        chk("timeout_data_released", {31'b0, ps2_data_oe}, 32'd0);
        chk("timeout_idle", {31'b0, busy}, 32'd0);
`else
        chk("no_timeout_pulse", {31'b0, timeout}, 32'd0);
        chk("stall_stays_busy", {31'b0, busy}, 32'd1);
`endif
        bfm_clk = 1'b1;
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(2);
        mon_en = 1'b1;

        txn(8'h81, 1'b1, 1'b1);

        for (int i = 0; i < 6; i++) begin
            rd = 8'($urandom_range(0, 255));
            ra = 1'($urandom_range(0, 1));
            txn(rd, ra, 1'b0);
        end

        chk("total_done", n_done, exp_done);
        chk("total_ack_err", n_err, exp_err);
        chk("pulse_while_busy", n_bad, 32'd0);
`ifdef PS2_TX_TIMEOUT_EN
        chk("total_timeout", n_tmo, 32'd1);
`else
        chk("total_timeout", n_tmo, 32'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
